// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment decode for the multiplexed 7-segment scan controller.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2,
    ST_OFF   = 2'd3
  } seg7_state_e;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Bit 0 is segment a, bit 6 is segment g; active-high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/down_counter.sv
// Free-running prescaler: o_count_hit is high for one enabled cycle out of every COUNT_FROM.
module down_counter #(
  parameter int COUNT_FROM = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_count_hit
);

  localparam int CW = (COUNT_FROM > 1) ? $clog2(COUNT_FROM) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(COUNT_FROM - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= RELOAD;
    end else if (i_en) begin
      if (r_cnt == '0) r_cnt <= RELOAD;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_count_hit = i_en && (r_cnt == '0);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: per-digit BLANK/ON/OFF slots for anti-ghosting and PWM
// brightness, with a valid/ready load buffer that only swaps the displayed digits at frame wrap.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_DIV     = 1000,
  parameter int BLANK_TICKS = 2,
  parameter int DIGIT_TICKS = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_load,
  output logic                    o_load_ready,
  input  logic [3:0]              i_brightness,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_dig,
  output logic                    o_frame_done
);

  localparam int TW     = $clog2(DIGIT_TICKS) + 1;
  localparam int IW     = $clog2(NUM_DIGITS);
  localparam int MAX_ON = DIGIT_TICKS - BLANK_TICKS;
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
  localparam logic [TW-1:0] MAX_ON_T   = TW'(MAX_ON);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  logic                    w_tick;
  seg7_state_e             r_state, w_nxt_state;
  logic [TW-1:0]           r_tcnt, w_nxt_tcnt;
  logic [IW-1:0]           r_idx, w_nxt_idx;
  logic [TW-1:0]           r_on_len, r_off_len, w_on_samp, w_off_samp;
  logic                    w_slot_start, w_slot_end, w_wrap, w_copy;
  logic [4*NUM_DIGITS-1:0] r_pend_dig, r_act_dig, w_act_dig_nxt;
  logic [NUM_DIGITS-1:0]   r_pend_dp, r_act_dp, w_act_dp_nxt;
  logic                    r_ready, r_copied;
  logic [6:0]              r_seg, w_seg_nxt;
  logic                    r_dp, w_dp_nxt;
  logic [NUM_DIGITS-1:0]   r_dig, w_dig_nxt;
  logic                    r_frame_done;
  logic [3:0]              w_nib;

  down_counter #(.COUNT_FROM(CLK_DIV)) u_prescaler (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .o_count_hit (w_tick)
  );

  always_comb begin
    if (int'(i_brightness) > MAX_ON) w_on_samp = MAX_ON_T;
    else                             w_on_samp = TW'(i_brightness);
    w_off_samp = MAX_ON_T - w_on_samp;
  end

  // Slot sequencer: all phase changes wait for a tick except leaving IDLE and dropping i_en.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_tcnt   = r_tcnt;
    w_nxt_idx    = r_idx;
    w_slot_start = 1'b0;
    w_slot_end   = 1'b0;
    w_wrap       = 1'b0;
    if (!i_en) begin
      w_nxt_state = ST_IDLE;
      w_nxt_tcnt  = '0;
      w_nxt_idx   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_nxt_state  = ST_BLANK;
          w_nxt_tcnt   = '0;
          w_nxt_idx    = '0;
          w_slot_start = 1'b1;
        end
        ST_BLANK: if (w_tick) begin
          if (r_tcnt == BLANK_LAST) begin
            w_nxt_tcnt = '0;
            if (r_on_len != '0)       w_nxt_state = ST_ON;
            else if (r_off_len != '0) w_nxt_state = ST_OFF;
            else                      w_slot_end  = 1'b1;
          end else begin
            w_nxt_tcnt = r_tcnt + 1'b1;
          end
        end
        ST_ON: if (w_tick) begin
          if (r_tcnt == r_on_len - 1'b1) begin
            w_nxt_tcnt = '0;
            if (r_off_len != '0) w_nxt_state = ST_OFF;
            else                 w_slot_end  = 1'b1;
          end else begin
            w_nxt_tcnt = r_tcnt + 1'b1;
          end
        end
        ST_OFF: if (w_tick) begin
          if (r_tcnt == r_off_len - 1'b1) w_slot_end = 1'b1;
          else                            w_nxt_tcnt = r_tcnt + 1'b1;
        end
        default: w_nxt_state = ST_IDLE;
      endcase
      if (w_slot_end) begin
        w_nxt_state  = ST_BLANK;
        w_nxt_tcnt   = '0;
        w_slot_start = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_nxt_idx = '0;
          w_wrap    = 1'b1;
        end else begin
          w_nxt_idx = r_idx + 1'b1;
        end
      end
    end
  end

  // Pending contents become visible only at a frame wrap, or straight away while idle.
  assign w_copy        = !r_ready && !r_copied && (w_wrap || (r_state == ST_IDLE));
  assign w_act_dig_nxt = w_copy ? r_pend_dig : r_act_dig;
  assign w_act_dp_nxt  = w_copy ? r_pend_dp  : r_act_dp;

  always_comb begin
    w_nib     = w_act_dig_nxt[4*w_nxt_idx +: 4];
    w_dig_nxt = '0;
    w_seg_nxt = '0;
    w_dp_nxt  = 1'b0;
    if (w_nxt_state == ST_ON) begin
      w_dig_nxt = NUM_DIGITS'(1) << w_nxt_idx;
      w_seg_nxt = hex_to_seg(w_nib);
      w_dp_nxt  = w_act_dp_nxt[w_nxt_idx];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_tcnt       <= '0;
      r_idx        <= '0;
      r_on_len     <= '0;
      r_off_len    <= '0;
      r_pend_dig   <= '0;
      r_pend_dp    <= '0;
      r_act_dig    <= '0;
      r_act_dp     <= '0;
      r_ready      <= 1'b1;
      r_copied     <= 1'b0;
      r_seg        <= '0;
      r_dp         <= 1'b0;
      r_dig        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_tcnt       <= w_nxt_tcnt;
      r_idx        <= w_nxt_idx;
      if (w_slot_start) begin
        r_on_len  <= w_on_samp;
        r_off_len <= w_off_samp;
      end
      r_frame_done <= w_wrap;
      r_act_dig    <= w_act_dig_nxt;
      r_act_dp     <= w_act_dp_nxt;
      if (r_ready) begin
        if (i_load) begin
          r_pend_dig <= i_digits;
          r_pend_dp  <= i_dp;
          r_ready    <= 1'b0;
        end
      end else if (r_copied) begin
        r_ready  <= 1'b1;
        r_copied <= 1'b0;
      end else if (w_copy) begin
        r_copied <= 1'b1;
      end
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
      r_dig <= w_dig_nxt;
    end
  end

  assign o_seg        = r_seg;
  assign o_dp         = r_dp;
  assign o_dig        = r_dig;
  assign o_frame_done = r_frame_done;
  assign o_load_ready = r_ready;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NUM_DIGITS=4, CLK_DIV=4, BLANK_TICKS=2, DIGIT_TICKS=8.
module tb_seg7_scan_ctrl;
  import seg7_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dpi = '0;
  logic [3:0]  bri = '0;
  logic        load_ready;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  seg7_scan_ctrl #(
    .NUM_DIGITS(4), .CLK_DIV(4), .BLANK_TICKS(2), .DIGIT_TICKS(8)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_digits(digits), .i_dp(dpi),
    .i_load(load), .o_load_ready(load_ready), .i_brightness(bri),
    .o_seg(seg), .o_dp(dp), .o_dig(dig), .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  bri;
    int          on_clks;
    logic [27:0] segs;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_word(input logic [15:0] d, input logic [3:0] p);
    digits = d; dpi = p; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_fd(input string name);
    int n = 0;
    @(negedge clk);
    while (!frame_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, frame_done, 1);
  endtask

  task automatic wait_dig(input string name, input logic [3:0] target);
    int n = 0;
    while (dig !== target && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, dig, target);
  endtask

  // One steady-state frame observed from just after a wrap to the next wrap.
  task automatic run_vec(input int vi, input vec_t v);
    int         on_cnt[4];
    logic [6:0] seen_seg[4];
    logic       seen_dp[4];
    int first0, fd_cnt, fd_at, bad;
    logic [6:0] exp_seg;
    first0 = -1; fd_cnt = 0; fd_at = -1; bad = 0;
    for (int i = 0; i < 4; i++) begin
      on_cnt[i] = 0; seen_seg[i] = '0; seen_dp[i] = 1'b0;
    end
    do_reset();
    load_word(v.digits, v.dp);
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d_ready", vi), load_ready, 1);
    bri = v.bri;
    en  = 1'b1;
    wait_fd($sformatf("v%0d_first_fd", vi));
    for (int k = 1; k <= 128; k++) begin
      @(negedge clk);
      if (frame_done) begin fd_cnt++; fd_at = k; end
      if (dig == 4'b0000) begin
        if (seg != 7'h00 || dp != 1'b0) bad++;
      end else begin
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (dig == (4'b0001 << i)) begin
            hit = 1'b1;
            on_cnt[i]++;
            seen_seg[i] = seg;
            seen_dp[i]  = dp;
            if (i == 0 && first0 < 0) first0 = k;
          end
        end
        if (!hit) bad++;
      end
    end
    chk($sformatf("v%0d_fd_count", vi), fd_cnt, 1);
    chk($sformatf("v%0d_fd_period", vi), fd_at, 128);
    chk($sformatf("v%0d_illegal_out", vi), bad, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("v%0d_on_clks_d%0d", vi, i), on_cnt[i], v.on_clks);
      if (v.on_clks > 0) begin
        exp_seg = v.segs[7*i +: 7];
        chk($sformatf("v%0d_seg_d%0d", vi, i), seen_seg[i], exp_seg);
        chk($sformatf("v%0d_dp_d%0d", vi, i), seen_dp[i], v.dp[i]);
      end
    end
    if (v.on_clks > 0) chk($sformatf("v%0d_blank_clks", vi), first0, 8);
  endtask

  initial begin
    int zeros, fd_cnt, dig_cnt;
    vecs[0] = '{16'h1234, 4'b0000, 4'd3,  12, {7'h06, 7'h5B, 7'h4F, 7'h66}};
    vecs[1] = '{16'hABCD, 4'b0101, 4'd15, 24, {7'h77, 7'h7C, 7'h39, 7'h5E}};
    vecs[2] = '{16'h0000, 4'b0000, 4'd0,  0,  {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    vecs[3] = '{16'h89EF, 4'b1010, 4'd6,  24, {7'h7F, 7'h6F, 7'h79, 7'h71}};
    vecs[4] = '{16'h5670, 4'b0110, 4'd1,  4,  {7'h6D, 7'h7D, 7'h07, 7'h3F}};

    // Reset held, then released with scanning disabled.
    repeat (3) @(negedge clk);
    chk("rst_outputs", {seg, dp, dig, frame_done, load_ready}, 14'h0001);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c % 10 == 9) chk($sformatf("idle_outputs_c%0d", c), {seg, dp, dig, frame_done, load_ready}, 14'h0001);
    end

    for (int vi = 0; vi < 5; vi++) run_vec(vi, vecs[vi]);

    // Mid-frame load is held back until the wrap; a second load while busy is dropped.
    do_reset();
    load_word(16'h1234, 4'b0000);
    repeat (3) @(negedge clk);
    bri = 4'd3; en = 1'b1;
    wait_fd("mid_first_fd");
    repeat (40) @(negedge clk);
    load_word(16'hABCD, 4'b0000);
    chk("mid_ready_low", load_ready, 0);
    load_word(16'hFFFF, 4'b1111);
    wait_dig("mid_d2_on", 4'b0100);
    chk("mid_d2_old_seg", seg, 7'h5B);
    wait_dig("mid_d3_on", 4'b1000);
    chk("mid_d3_old_seg", seg, 7'h06);
    wait_fd("mid_wrap_fd");
    chk("mid_ready_at_wrap", load_ready, 0);
    @(negedge clk);
    chk("mid_ready_after_wrap", load_ready, 1);
    wait_dig("mid_new_d0_on", 4'b0001);
    chk("mid_new_d0_seg", seg, 7'h5E);
    chk("mid_new_d0_dp", dp, 0);

    // Disable during digit 2 ON, then re-enable.
    wait_dig("dis_d2_on", 4'b0100);
    en = 1'b0;
    @(negedge clk);
    chk("dis_dig_off", {seg, dig}, 11'h000);
    fd_cnt = 0; dig_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (dig != 4'b0000) dig_cnt++;
    end
    chk("dis_no_fd", fd_cnt, 0);
    chk("dis_no_dig", dig_cnt, 0);
    chk("dis_ready_kept", load_ready, 1);
    en = 1'b1;
    zeros = 0;
    @(negedge clk);
    while (dig == 4'b0000 && zeros < 400) begin
      zeros++;
      @(negedge clk);
    end
    chk("reen_first_digit", dig, 4'b0001);
    chk("reen_blank_first", zeros >= 4, 1);
    chk("reen_seg", seg, 7'h5E);

    // Asynchronous reset during ON with a load pending.
    bri = 4'd15;
    wait_fd("rst_wrap_fd");
    wait_dig("rst_d0_on", 4'b0001);
    load_word(16'h89EF, 4'b0000);
    chk("rst_pending_ready", load_ready, 0);
    #2 rst = 1'b1;
    #1 chk("rst_async_outputs", {seg, dp, dig, frame_done, load_ready}, 14'h0001);
    @(negedge clk);
    rst = 1'b0;
    wait_dig("rst_after_d0_on", 4'b0001);
    chk("rst_after_d0_seg", seg, 7'h3F);
    wait_fd("rst_after_fd");
    wait_dig("rst_after_d1_on", 4'b0010);
    chk("rst_pending_dropped", seg, 7'h3F);
    chk("rst_after_ready", load_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Multiplexed 7-segment display scan controller for the demo's NUM_DIGITS-digit common-segment display.
- Uses a down_counter prescaler to derive a scan tick and sequences digit enables through blanking, on and off phases per digit slot, which gives anti-ghosting and PWM brightness.
- Accepts new display contents through a valid/ready handshake and applies them only at frame boundaries, so updates are tear-free.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits, 2..8.
- CLK_DIV, 1000: i_clk cycles per scan tick; passed as COUNT_FROM to down_counter.
- BLANK_TICKS, 2: ticks with all digits off at the start of each slot.
- DIGIT_TICKS, 16: ticks per digit slot. Must be greater than BLANK_TICKS.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: reset, asynchronous, active-high.
- i_en, in, 1: scan enable. Also the count enable of the prescaler.
- i_digits, in, 4*NUM_DIGITS: hex nibbles. Digit 0 is bits [3:0].
- i_dp, in, NUM_DIGITS: decimal-point per digit.
- i_load, in, 1: load valid.
- o_load_ready, out, 1: load ready.
- i_brightness, in, 4: on-time in ticks per slot.
- o_seg, out, 7: segments, active-high. Bit 0 is segment a, bit 6 is segment g.
- o_dp, out, 1: decimal point, active-high.
- o_dig, out, NUM_DIGITS: one-hot digit enable, active-high.
- o_frame_done, out, 1: one-cycle pulse at digit wrap.

Behaviour:
- Reset values:
  - o_seg, o_dp, o_dig, o_frame_done = 0; o_load_ready = 1.
  - Active and pending digit/dp registers = 0; digit index = 0; FSM = IDLE.
  - These values must not depend on the prescaler output.
- Tick: the down_counter count_hit is one cycle high every CLK_DIV enabled clocks. Every FSM transition below happens only on a tick cycle, unless stated otherwise.
- FSM states: IDLE, BLANK, ON, OFF. A per-state tick counter has width $clog2(DIGIT_TICKS)+1.
  - IDLE: when i_en=1, go to BLANK on the next clock (no tick needed). Index = 0.
  - Slot start: when entering BLANK, sample i_brightness into on_len = min(i_brightness, DIGIT_TICKS-BLANK_TICKS). off_len = DIGIT_TICKS - BLANK_TICKS - on_len.
  - BLANK: after BLANK_TICKS ticks, go to ON. If on_len=0, go to OFF instead; if off_len is also 0, go to end-of-slot.
  - ON: after on_len ticks, go to OFF, or to end-of-slot if off_len=0.
  - OFF: after off_len ticks, go to end-of-slot.
  - End-of-slot: index+1 and enter BLANK. When index=NUM_DIGITS-1, wrap to 0 and pulse o_frame_done for exactly one clock on the same edge.
- Outputs are registered and update on the edge where the FSM enters or leaves ON.
  - In ON: o_dig = one-hot(index), o_seg = hex decode of active nibble[index], o_dp = active dp[index].
  - In all other states: o_dig, o_seg and o_dp are 0.
- Hex decode, 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Load handshake:
  - i_load & o_load_ready captures i_digits/i_dp into pending and drops o_load_ready on the next edge.
  - i_load while ready=0 is ignored; pending is not overwritten.
  - Pending is copied to active on the frame-wrap edge, or on the next clock if the FSM is IDLE. o_load_ready returns to 1 on the edge after the copy.
- i_en fall: on the next clock go to IDLE, blank all outputs, set index = 0 and suppress o_frame_done. Pending state and ready are preserved.
- Re-enable: always restarts at digit 0 BLANK.
- Prescaler phase is not reset by i_en; the first slot may be up to one tick short.
- i_rst mid-operation: immediate return to reset values. Any pending load is discarded.

Decomposition:
- Package seg7_pkg holds:
  - state enum type (IDLE/BLANK/ON/OFF);
  - the hex-to-segment decode function (constant 16-entry table above);
  - segment bit-index constants.
- Sub-module: the existing down_counter instantiated as the tick prescaler.
- Slot FSM, load buffer and output registers stay in seg7_scan_ctrl.

Test Plan:
All cases use NUM_DIGITS=4, CLK_DIV=4, BLANK_TICKS=2, DIGIT_TICKS=8; a frame is 128 clocks.
1. Reset held, then released with i_en=0 -> all outputs 0, o_load_ready=1, indefinitely.
2. Load i_digits=0x1234 while IDLE, then i_en=1, brightness=3:
   - o_dig=0001 with o_seg=0x66 for 12 clocks, after 8 blank clocks.
   - Then o_dig=0010 with o_seg=0x4F.
   - o_frame_done pulses every 128 clocks.
3. brightness=0 -> o_dig never nonzero; o_frame_done still every 128 clocks. brightness=15 -> clamped: on 24 clocks, no OFF phase, continuous ON per slot after blank.
4. Mid-frame load of 0xABCD -> rest of frame still shows 0x1234 digits. From the next frame digit 0 shows 0x5E. ready low until the edge after the wrap. A second i_load during ready=0 has no effect.
5. i_en dropped during ON of digit 2 -> next clock o_dig=0 and no o_frame_done. Re-enable -> digit 0 BLANK first.
6. i_rst asserted mid-ON with a load pending -> outputs 0 asynchronously, ready=1. After release, active display = 0000.
